// File: rtl/refresh_scheduler.sv
// Refresh scheduler: paces refresh obligations with an interval timer, asks a skip
// tracker whether each row is in use, and issues or skips the refresh accordingly.
module refresh_scheduler #(
  parameter int ROW_WIDTH    = 16,
  parameter int T_REFI       = 3900,
  parameter int T_RFC        = 280,
  parameter int MAX_POSTPONE = 8,
  localparam int PW          = $clog2(MAX_POSTPONE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ref_en,
  output logic                 query_valid,
  output logic [ROW_WIDTH-1:0] query_row,
  input  logic                 query_dref,
  output logic                 ref_req,
  output logic [ROW_WIDTH-1:0] ref_row,
  input  logic                 ref_ack,
  output logic                 busy,
  output logic                 urgent,
  output logic                 overflow,
  output logic [PW-1:0]        pending,
  output logic [15:0]          skip_cnt
);

  // state     | meaning
  // IDLE      | waiting for an outstanding obligation while enabled
  // QUERY     | one-cycle question to the skip tracker about the current row
  // WAIT_DREF | tracker answer sampled: skip the row or go request a refresh
  // REQ       | refresh request held until the arbiter acknowledges
  // RFC       | post-refresh busy window of T_RFC cycles
  typedef enum logic [2:0] {IDLE, QUERY, WAIT_DREF, REQ, RFC} state_t;

  localparam int TW = $clog2(T_REFI + 1);
  localparam int CW = $clog2(T_RFC + 1);

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [PW-1:0]        pend_q, pend_d;
  logic [15:0]          skip_q, skip_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        rfc_q, rfc_d;
  logic                 tick;
  logic                 retire;

  assign tick = ref_en && (timer_q == TW'(T_REFI - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    skip_d  = skip_q;
    rfc_d   = rfc_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:      if (ref_en && (pend_q != '0)) state_d = QUERY;
      QUERY:     state_d = WAIT_DREF;
      WAIT_DREF: begin
        if (query_dref) begin
          retire  = 1'b1;
          row_d   = row_q + ROW_WIDTH'(1);
          skip_d  = skip_q + 16'd1;
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ref_ack) begin
          retire  = 1'b1;
          row_d   = row_q + ROW_WIDTH'(1);
          rfc_d   = CW'(T_RFC - 1);
          state_d = RFC;
        end
      end
      RFC: begin
        if (rfc_q == '0) state_d = IDLE;
        else             rfc_d   = rfc_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A tick and a retirement in the same cycle cancel; at saturation that is not an overflow.
  always_comb begin
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (ref_en) timer_d = tick ? '0 : timer_q + TW'(1);
    if (tick && !retire) begin
      if (pend_q == PW'(MAX_POSTPONE)) ovf_d  = 1'b1;
      else                             pend_d = pend_q + PW'(1);
    end else if (!tick && retire) begin
      pend_d = pend_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      row_q   <= '0;
      pend_q  <= '0;
      skip_q  <= '0;
      ovf_q   <= 1'b0;
      rfc_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      pend_q  <= pend_d;
      skip_q  <= skip_d;
      ovf_q   <= ovf_d;
      rfc_q   <= rfc_d;
    end
  end

  assign query_valid = (state_q == QUERY);
  assign query_row   = row_q;
  assign ref_req     = (state_q == REQ);
  assign ref_row     = row_q;
  assign busy        = (state_q != IDLE);
  assign urgent      = (pend_q == PW'(MAX_POSTPONE));
  assign overflow    = ovf_q;
  assign pending     = pend_q;
  assign skip_cnt    = skip_q;

endmodule
